// File: rtl/multu_unit_if.sv
// Start/read-select bus and HI/LO result bus between the ALU datapath and multu_unit.
interface multu_unit_if #(
  parameter int WIDTH = 32
);
  logic             multuOp;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [1:0]       total_alu_sel;
  logic [WIDTH-1:0] dataOut;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output multuOp, dataA, dataB, total_alu_sel,
    input  dataOut, hi, lo, busy, done
  );

  modport slave (
    input  multuOp, dataA, dataB, total_alu_sel,
    output dataOut, hi, lo, busy, done
  );
endinterface

// File: rtl/multu_unit.sv
// Shift-add unsigned multiplier into HI/LO: WIDTH busy cycles, starts ignored while busy.
// Optional MULTU_EARLY_EXIT_EN finishes once the remaining multiplier bits are all zero.
module multu_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  multu_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0]   mplier_shift;
  logic [2*WIDTH-1:0] result;
  logic               last;
`ifdef MULTU_EARLY_EXIT_EN
  logic [CW-1:0]      rem;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // Carry out of the upper-half add is kept and shifted back into the accumulator.
    sum          = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_shift    = {sum, acc_q[WIDTH-1:1]};
    mplier_shift = mplier_q >> 1;
    last         = (count_q == CW'(WIDTH - 1));
`ifdef MULTU_EARLY_EXIT_EN
    // Skipped iterations would only shift, so apply those shifts in one go.
    rem    = CW'(WIDTH - 1) - count_q;
    result = acc_shift >> rem;
    last   = last || (mplier_shift == '0);
`else
    result = acc_shift;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.multuOp) begin
          mcand_d  = bus.dataA;
          mplier_d = bus.dataB;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_shift;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (last) begin
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == BUSY);
  assign bus.done = (state_q == DONE);

  always_comb begin
    bus.dataOut = '0;
    case (bus.total_alu_sel)
      2'b01:   bus.dataOut = hi_q;
      2'b10:   bus.dataOut = lo_q;
      default: bus.dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_unit.sv
// Directed-vector bench for multu_unit: reset, max operands, ignored restart, read select,
// reset abort and back-to-back operation.
module tb_multu_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multu_unit_if #(.WIDTH(W)) bus();

  multu_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef MULTU_EARLY_EXIT_EN
  localparam int INJ = 2;
`else
  localparam int INJ = 4;
`endif

  function automatic int exp_busy(input logic [31:0] b);
    int r;
`ifdef MULTU_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < 32; i++) if (b[i]) r = i + 1;
`else
    r = 32;
    if (^b === 1'bx) r = 0;
`endif
    return r;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.dataA   = a;
    bus.dataB   = b;
    bus.multuOp = 1'b1;
    @(negedge clk);
    bus.multuOp = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [1:0] s;
    rst_n = 1'b0;
    bus.multuOp = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    bus.total_alu_sel = 2'b00;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy_in_reset: got %b want 0", bus.busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.hi !== 32'h0) $display("FAIL rst_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'h0) $display("FAIL rst_lo: got %h want 0", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passed++;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      bus.total_alu_sel = s;
      #1;
      checks++; if (bus.dataOut !== 32'h0) $display("FAIL rst_dataOut sel=%0d: got %h want 0", i, bus.dataOut); else passed++;
    end
  endtask

  task automatic test_max;
    int n;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy(n);
    checks++; if (n !== exp_busy(32'hFFFF_FFFF)) $display("FAIL max_busy_len: got %0d want %0d", n, exp_busy(32'hFFFF_FFFF)); else passed++;
    checks++; if (bus.done !== 1'b1) $display("FAIL max_done: got %b want 1", bus.done); else passed++;
    checks++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL max_hi: got %h want fffffffe", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'h0000_0001) $display("FAIL max_lo: got %h want 00000001", bus.lo); else passed++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL max_done_pulse: got %b want 0", bus.done); else passed++;
  endtask

  task automatic test_ignore;
    int dones;
    start_op(32'd3, 32'd5);
    repeat (INJ - 1) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL ign_busy_at_inject: got %b want 1", bus.busy); else passed++;
    bus.multuOp = 1'b1;
    bus.dataA   = 32'd7;
    bus.dataB   = 32'd7;
    @(negedge clk);
    bus.multuOp = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 1) $display("FAIL ign_done_count: got %0d want 1", dones); else passed++;
    checks++; if (bus.hi !== 32'd0) $display("FAIL ign_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd15) $display("FAIL ign_lo: got %h want f", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL ign_idle: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_sel;
    int n;
    logic [31:0] exp_out [4];
    logic [1:0]  s;
    exp_out[0] = 32'd0; exp_out[1] = 32'd1; exp_out[2] = 32'd0; exp_out[3] = 32'd0;
    start_op(32'h0001_0000, 32'h0001_0000);
    wait_busy(n);
    checks++; if (n !== exp_busy(32'h0001_0000)) $display("FAIL sel_busy_len: got %0d want %0d", n, exp_busy(32'h0001_0000)); else passed++;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      bus.total_alu_sel = s;
      #1;
      checks++; if (bus.dataOut !== exp_out[i]) $display("FAIL sel_dataOut sel=%0d: got %h want %h", i, bus.dataOut, exp_out[i]); else passed++;
    end
    start_op(32'd5, 32'd5);
    bus.total_alu_sel = 2'b01;
    #1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL sel_second_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.dataOut !== 32'd1) $display("FAIL sel_hold_dataOut: got %h want 1", bus.dataOut); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL sel_hold_lo: got %h want 0", bus.lo); else passed++;
    wait_busy(n);
    checks++; if (bus.hi !== 32'd0) $display("FAIL sel_second_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd25) $display("FAIL sel_second_lo: got %h want 19", bus.lo); else passed++;
  endtask

  task automatic test_reset_busy;
    int dones, busys;
    start_op(32'h1234, 32'hFFFF);
    repeat (9) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL rb_busy_before: got %b want 1", bus.busy); else passed++;
    bus.total_alu_sel = 2'b10;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'd0) $display("FAIL rb_hi: got %h want 0", bus.hi); else passed++;
    checks++; if (bus.lo !== 32'd0) $display("FAIL rb_lo: got %h want 0", bus.lo); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rb_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rb_done: got %b want 0", bus.done); else passed++;
    checks++; if (bus.dataOut !== 32'd0) $display("FAIL rb_dataOut: got %h want 0", bus.dataOut); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    busys = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busys++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) $display("FAIL rb_no_done: got %0d want 0", dones); else passed++;
    checks++; if (busys !== 0) $display("FAIL rb_no_busy: got %0d want 0", busys); else passed++;
  endtask

  task automatic test_back_to_back;
    int last_done, pulses, period;
    period = exp_busy(32'd3) + 1;
    @(negedge clk);
    bus.dataA = 32'd2;
    bus.dataB = 32'd3;
    bus.total_alu_sel = 2'b10;
    bus.multuOp = 1'b1;
    last_done = -1;
    pulses = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (bus.done === 1'b1) begin
        checks++; if (bus.lo !== 32'd6) $display("FAIL b2b_lo: got %h want 6", bus.lo); else passed++;
        checks++; if (bus.dataOut !== 32'd6) $display("FAIL b2b_dataOut: got %h want 6", bus.dataOut); else passed++;
        if (last_done >= 0) begin
          checks++; if (cyc - last_done !== period) $display("FAIL b2b_period: got %0d want %0d", cyc - last_done, period); else passed++;
        end
        last_done = cyc;
        pulses++;
      end
      @(negedge clk);
    end
    bus.multuOp = 1'b0;
    checks++; if (pulses < 3) $display("FAIL b2b_pulses: got %0d want >=3", pulses); else passed++;
    repeat (40) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", bus.busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_max();
    test_ignore();
    test_sel();
    test_reset_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
